// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the RV32M multiply/divide sequencer
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shift-add / restoring-divide datapath with sign correction
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_load_div,
  input  logic [XLEN-1:0] i_mag_a,
  input  logic [XLEN-1:0] i_mag_b,
  input  logic            i_step,
  input  logic [2:0]      i_funct3,
  input  logic            i_sa,
  input  logic            i_sb,
  output logic [XLEN-1:0] o_result
);

  // Multiply: r_acc = {partial_hi, remaining multiplier}; r_opnd = multiplicand.
  // Divide:   r_acc = {partial remainder, dividend/quotient}; r_opnd = divisor.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;

  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_shl;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;

  // One iteration: conditional add then shift right (mul), or shift left then trial subtract (div)
  always_comb begin
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_shl  = {r_acc[2*XLEN-2:0], 1'b0};
    // The shifted remainder can need XLEN+1 bits, so the trial uses the bit shifted out.
    w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    if (i_funct3[2]) begin
      if (!w_diff[XLEN]) begin
        w_acc_next = {w_diff[XLEN-1:0], w_shl[XLEN-1:1], 1'b1};
      end else begin
        w_acc_next = w_shl;
      end
    end else begin
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  // Final sign correction and result selection, taken from the value of the last iteration
  always_comb begin
    w_prod = (i_sa ^ i_sb) ? -w_acc_next : w_acc_next;
    w_q    = w_acc_next[XLEN-1:0];
    w_r    = w_acc_next[2*XLEN-1:XLEN];
    case (i_funct3)
      F3_MUL:                       o_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              o_result = (i_sa ^ i_sb) ? -w_q : w_q;
      default:                      o_result = i_sa ? -w_r : w_r;
    endcase
  end

  // Accumulator and operand registers: load on accept, advance once per CALC cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= {{XLEN{1'b0}}, (i_load_div ? i_mag_a : i_mag_b)};
      r_opnd <= i_load_div ? i_mag_b : i_mag_a;
    end else if (i_step) begin
      r_acc  <= w_acc_next;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M sequencer: FSM, counter, fast path and pipeline handshake
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic            r_sa;
  logic            r_sb;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_last;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_core_result;

  assign w_accept = (r_state == IDLE) && start_i && !kill_i;
  assign w_last   = (r_state == CALC) && (r_cnt == CW'(1));
  assign busy_o   = (r_state != IDLE);
  assign result_o = r_result;

  // Operand signs: only the operands treated as signed by this funct3 contribute a sign
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (funct3_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        w_sa = rs1_data_i[XLEN-1];
        w_sb = rs2_data_i[XLEN-1];
      end
      F3_MULHSU: w_sa = rs1_data_i[XLEN-1];
      default: ;
    endcase
    w_mag_a = w_sa ? -rs1_data_i : rs1_data_i;
    w_mag_b = w_sb ? -rs2_data_i : rs2_data_i;
  end

  // Fast path: divide by zero and signed overflow bypass the iteration loop
  always_comb begin
    w_div0 = funct3_i[2] && (rs2_data_i == '0);
    w_ovf  = funct3_i[2] && !funct3_i[0]
             && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
             && (rs2_data_i == '1);
    w_fast = w_div0 || w_ovf;
    if (w_div0) begin
      w_fast_result = funct3_i[1] ? rs1_data_i : '1;
    end else begin
      w_fast_result = funct3_i[1] ? '0 : rs1_data_i;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs; stall is combinational so EX holds from cycle 0
  always_comb begin
    w_state_next = r_state;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        stall_o = start_i && !kill_i;
        if (w_accept) begin
          w_state_next = w_fast ? DONE : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (kill_i) begin
          w_state_next = IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Latched operation, iteration counter and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_funct3 <= funct3_i;
      r_sa     <= w_sa;
      r_sb     <= w_sb;
      r_cnt    <= CW'(XLEN);
      if (w_fast) begin
        r_result <= w_fast_result;
      end
    end else if ((r_state == CALC) && !kill_i) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= w_core_result;
      end
    end
  end

  muldiv_core #(
    .XLEN(XLEN)
  ) u_core (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_accept),
    .i_load_div (funct3_i[2]),
    .i_mag_a    (w_mag_a),
    .i_mag_b    (w_mag_b),
    .i_step     (r_state == CALC),
    .i_funct3   (r_funct3),
    .i_sa       (r_sa),
    .i_sb       (r_sb),
    .o_result   (w_core_result)
  );

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the main ALU.
- Decoder raises start_i for M-extension instructions (funct7 = 0000001); this block latches operands, runs a shift-add or restoring-divide loop, and returns one result.
- stall_o freezes the PC and pipeline registers until the result is delivered; done_o marks the single writeback cycle.

Parameters:
XLEN, 32, operand/result width; iteration counter width is $clog2(XLEN)+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  M-extension instruction present in EX; level, held by stall until done
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data_i  input  XLEN  operand A / dividend
rs2_data_i  input  XLEN  operand B / divisor
kill_i  input  1  flush; abort current operation
busy_o  output  1  state != IDLE
stall_o  output  1  hold pipeline
done_o  output  1  result_o valid this cycle (one-cycle pulse)
result_o  output  XLEN  result; registered, held until next accepted start

Behaviour:
- Reset: state IDLE, busy_o=0, done_o=0, stall_o=0, result_o=0, all internal registers 0. Reset mid-operation aborts with no done_o.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and kill_i=0: latch funct3 and operands, compute sign flags, convert operands to magnitudes, load counter=XLEN.
  - Fast-path cases go IDLE->DONE with the result preloaded; all others go to CALC.
- CALC:
  - One iteration per cycle; counter decrements; when counter reaches 1, next state is DONE.
  - The final cycle writes the sign-corrected result into result_o.
- DONE: done_o=1, stall_o=0, so the pipeline advances this cycle. start_i is ignored. Always returns to IDLE.
- stall_o = (IDLE & start_i & ~kill_i) | CALC. Combinational, so the requesting instruction never advances early.
- Latency (start cycle = cycle 0):
  - Normal: done_o in cycle XLEN+1 (33 for XLEN=32); stall_o high cycles 0..XLEN.
  - Fast path: done_o in cycle 1.
- Multiply (shift-add):
  - 2*XLEN accumulator on |A|*|B|.
  - Negate the product if signs differ: MUL/MULH use both signs, MULHSU uses the A sign only, MULHU is unsigned.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide (restoring): XLEN iterations on |A|, |B|.
  - Quotient sign = sA^sB; remainder sign = sA (signed ops only).
- Fast path:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> A.
  - Signed overflow (A = -2^(XLEN-1), B = -1): DIV -> A; REM -> 0.
- kill_i:
  - In IDLE, blocks acceptance.
  - In CALC or DONE, next state is IDLE, done_o is suppressed in the following cycle, and result_o is unchanged.
  - kill_i has priority over start_i.
- Operand or funct3 changes while busy are ignored (latched copies only).

Decomposition:
- Shared package muldiv_pkg:
  - funct3 encodings as localparams: F3_MUL..F3_REMU.
  - FUNCT7_MULDIV = 7'b0000001.
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- One natural sub-module: muldiv_core, a datapath only. It holds the accumulator/remainder register, one iteration step and the final sign correction.
- muldiv_seq keeps the FSM, counter, fast-path detection and handshake.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD, start at cycle 0 -> stall_o high cycles 0..32, done_o only at cycle 33, result_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each has done_o at cycle 33.
- Fast path -> done_o at cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- kill_i at cycle 10 of a DIV -> IDLE at cycle 11, no done_o, result_o retains its prior value. A new start at cycle 12 completes normally.
- rst_i at cycle 5 of a MUL -> all outputs 0 next cycle. Back-to-back MUL then DIV (start re-asserted the cycle after done_o) -> both results correct, no lost or duplicate done_o.
